// File: rtl/div_sequencer_pkg.sv
// Shared types and sizing helpers for the divider front-end sequencer.
package div_sequencer_pkg;

  // Sequencer phases: wait for work, pulse the divider, wait for result, hand result out.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // div_n is a fixed 4-bit field on the divider interface.
  localparam int unsigned DIV_N_W = 4;

  // Bits needed to hold values 0..max_val inclusive (counters that must reach max_val).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(max_val + 32'd1);
    end
  endfunction

  // Bits needed to index n entries (pointers that wrap mod n).
  function automatic int unsigned ptr_width(input int unsigned n);
    if (n < 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO: holds {dividend, divisor} pairs until the sequencer is free.
// Registered count drives full/empty, so a push into an empty FIFO is only
// visible as non-empty from the following cycle (no bypass path).
module div_req_fifo
  import div_sequencer_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s;
  logic          pop_s;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_s  = push & ~full;
  assign pop_s   = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Next pointer and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Front end for the iterative divider: queues operand pairs, issues them one
// at a time, captures the result (or a watchdog timeout) and returns it on a
// valid/ready response port.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_dividend,
  input  logic [WIDTH-1:0]   req_divisor,
  output logic               div_go,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  output logic [DIV_N_W-1:0] div_n,
  input  logic               div_done,
  input  logic [WIDTH-1:0]   div_quotient,
  input  logic [WIDTH-1:0]   div_remainder,
  input  logic               div_error,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_quotient,
  output logic [WIDTH-1:0]   rsp_remainder,
  output logic               rsp_error,
  output logic               rsp_timeout,
  output logic               busy
);

  localparam int unsigned WDW = cnt_width(TIMEOUT);

  seq_state_e         state_q, state_d;
  logic               div_go_q, div_go_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WDW-1:0]     wdog_q, wdog_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_quot_q, rsp_quot_d;
  logic [WIDTH-1:0]   rsp_rem_q, rsp_rem_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_tout_q, rsp_tout_d;

  logic               push_s;
  logic               pop_s;
  logic [2*WIDTH-1:0] fifo_rd_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;

  // req_ready comes only from the registered count, so a full FIFO refuses a
  // push even in a cycle where an entry is being popped.
  assign req_ready = ~fifo_full_s;
  assign push_s    = req_valid & req_ready;

  div_req_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data ({req_dividend, req_divisor}),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign div_go        = div_go_q;
  assign div_dividend  = opa_q;
  assign div_divisor   = opb_q;
  assign div_n         = DIV_N_W'(WIDTH);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_quotient  = rsp_quot_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_error     = rsp_err_q;
  assign rsp_timeout   = rsp_tout_q;
  assign busy          = (state_q != ST_IDLE) | ~fifo_empty_s;

  // Next-state, pop control, watchdog and result capture for the issue FSM.
  always_comb begin
    state_d     = state_q;
    div_go_d    = 1'b0;
    opa_d       = opa_q;
    opb_d       = opb_q;
    wdog_d      = wdog_q;
    rsp_valid_d = rsp_valid_q;
    rsp_quot_d  = rsp_quot_q;
    rsp_rem_d   = rsp_rem_q;
    rsp_err_d   = rsp_err_q;
    rsp_tout_d  = rsp_tout_q;
    pop_s       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          // Operands stay on div_dividend/div_divisor until the next pop.
          pop_s    = 1'b1;
          opa_d    = fifo_rd_s[2*WIDTH-1 -: WIDTH];
          opb_d    = fifo_rd_s[WIDTH-1:0];
          div_go_d = 1'b1;
          state_d  = ST_ISSUE;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        wdog_d = wdog_q + WDW'(1);
        // wdog_q is zero only in the first WAIT cycle, where div_done may
        // still be the level left over from the previous operation.
        if ((wdog_q != '0) && div_done) begin
          rsp_quot_d  = div_quotient;
          rsp_rem_d   = div_remainder;
          rsp_err_d   = div_error;
          rsp_tout_d  = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (wdog_q == WDW'(TIMEOUT - 32'd1)) begin
          rsp_quot_d  = '0;
          rsp_rem_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_tout_d  = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          state_d     = ST_WAIT;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // FSM, operand, watchdog and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      div_go_q    <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      wdog_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_go_q    <= div_go_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      wdog_q      <= wdog_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_quot_q  <= rsp_quot_d;
      rsp_rem_q   <= rsp_rem_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tout_q  <= rsp_tout_d;
    end
  end

endmodule
